// File: rtl/datapath_mon_pkg.sv
// datapath_mon_pkg
//   Shared types and sizing helpers for the datapath run monitor.
//   - mon_state_e : monitor state, IDLE=0 RUN=1 HALTED=2 TIMEOUT=3
//   - LOG_IDX_W / LOG_CNT_W : log index / count widths for the default depth
//   - log_idx_w() / log_cnt_w() : the same widths for any power-of-two depth
package datapath_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_HALTED  = 2'd2,
      ST_TIMEOUT = 2'd3
   } mon_state_e;

   localparam int unsigned DEF_DEPTH = 8;
   localparam int unsigned LOG_IDX_W = $clog2(DEF_DEPTH);
   localparam int unsigned LOG_CNT_W = LOG_IDX_W + 1;

   function automatic int unsigned log_idx_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // One extra bit so a full log (count == depth) is representable.
   function automatic int unsigned log_cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/mon_log_buffer.sv
// mon_log_buffer
//   Circular log of the most recent distinct write-back values.
//   Ports:
//     clk, rst       : clock, synchronous active-high reset
//     clr_i          : restart the log (count and pointer to zero)
//     wr_req_i       : sample wd_i this cycle (monitor is running)
//     wd_i           : write-back value to log
//     rd_idx_i       : read index, 0 = newest entry
//     rd_data_o      : selected entry, 0 when rd_idx_i >= log_count_o
//     log_count_o    : number of valid entries, saturates at DEPTH
module mon_log_buffer
   import datapath_mon_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = DEF_DEPTH
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clr_i,
   input  logic                           wr_req_i,
   input  logic [DATA_W-1:0]              wd_i,
   input  logic [log_idx_w(DEPTH)-1:0]    rd_idx_i,
   output logic [DATA_W-1:0]              rd_data_o,
   output logic [log_cnt_w(DEPTH)-1:0]    log_count_o
);

   localparam int unsigned IDX_W  = log_idx_w(DEPTH);
   localparam int unsigned LCNT_W = log_cnt_w(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [LCNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0]  newest_ptr;
   logic [IDX_W-1:0]  rd_ptr;
   logic              wr_en;

   // Pointer arithmetic wraps naturally because DEPTH is a power of two.
   assign newest_ptr = wr_ptr_q - IDX_W'(1);
   assign rd_ptr     = newest_ptr - rd_idx_i;

   // Duplicate filter: only log a value that differs from the newest entry.
   assign wr_en = wr_req_i && !clr_i && !rst &&
                  ((cnt_q == '0) || (wd_i != mem_q[newest_ptr]));

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else if (wr_en) begin
         wr_ptr_d = wr_ptr_q + IDX_W'(1);
         if (cnt_q != LCNT_W'(DEPTH))
            cnt_d = cnt_q + LCNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: entries beyond cnt_q are masked on read.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[wr_ptr_q] <= wd_i;
   end

   assign rd_data_o   = ({1'b0, rd_idx_i} < cnt_q) ? mem_q[rd_ptr] : '0;
   assign log_count_o = cnt_q;

endmodule

// File: rtl/datapath_run_monitor.sv
// datapath_run_monitor
//   Watches a datapath's PC and write-back bus, declares completion on a PC
//   spin (HALT_CYCLES identical samples) or on a cycle-budget timeout, and
//   reports pass when the halting write-back equals the expected result.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     start           : arm / re-arm pulse, accepted in any state
//     pc_in, wd_in    : datapath ProgramCounter / WriteData
//     expected        : expected final write-back value
//     rd_idx, rd_data : newest-first log readout (combinational)
//     log_count       : valid log entries
//     cycle_count     : RUN cycles elapsed
//     state           : IDLE=0 RUN=1 HALTED=2 TIMEOUT=3
//     done/pass/timeout : verdict flags
module datapath_run_monitor
   import datapath_mon_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned PC_W        = 32,
   parameter int unsigned DEPTH       = DEF_DEPTH,
   parameter int unsigned HALT_CYCLES = 4,
   parameter int unsigned MAX_CYCLES  = 4096,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [PC_W-1:0]             pc_in,
   input  logic [DATA_W-1:0]           wd_in,
   input  logic [DATA_W-1:0]           expected,
   input  logic [log_idx_w(DEPTH)-1:0] rd_idx,
   output logic [DATA_W-1:0]           rd_data,
   output logic [log_cnt_w(DEPTH)-1:0] log_count,
   output logic [CNT_W-1:0]            cycle_count,
   output logic [1:0]                  state,
   output logic                        done,
   output logic                        pass,
   output logic                        timeout
);

   localparam int unsigned STAB_W = $clog2(HALT_CYCLES) + 1;

   mon_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cyc_q, cyc_d;
   logic [PC_W-1:0]   prev_pc_q, prev_pc_d;
   logic [STAB_W-1:0] stab_q, stab_d;
   logic              first_q, first_d;
   logic              pass_q, pass_d;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cyc_q     <= '0;
         prev_pc_q <= '0;
         stab_q    <= '0;
         first_q   <= 1'b0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         prev_pc_q <= prev_pc_d;
         stab_q    <= stab_d;
         first_q   <= first_d;
         pass_q    <= pass_d;
      end
   end

   // Next state: start overrides everything; RUN advances counters and
   // decides halt/timeout on the sample being taken this edge.
   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      prev_pc_d = prev_pc_q;
      stab_d    = stab_q;
      first_d   = first_q;
      pass_d    = pass_q;
      if (start) begin
         state_d = ST_RUN;
         cyc_d   = '0;
         stab_d  = '0;
         first_d = 1'b1;
         pass_d  = 1'b0;
      end else if (state_q == ST_RUN) begin
         cyc_d     = cyc_q + CNT_W'(1);
         prev_pc_d = pc_in;
         first_d   = 1'b0;
         // prev_pc is stale on the first sample of a run, so never compare it.
         if (first_q || (pc_in != prev_pc_q))
            stab_d = '0;
         else
            stab_d = stab_q + STAB_W'(1);
         // Halt is tested first so it wins a same-sample timeout.
         if (stab_d == STAB_W'(HALT_CYCLES - 1)) begin
            state_d = ST_HALTED;
            pass_d  = (wd_in == expected);
         end else if (cyc_d == CNT_W'(MAX_CYCLES)) begin
            state_d = ST_TIMEOUT;
         end
      end
   end

   // Outputs: plain decodes of registered state
   always_comb begin
      state       = state_q;
      cycle_count = cyc_q;
      pass        = pass_q;
      done        = (state_q == ST_HALTED) || (state_q == ST_TIMEOUT);
      timeout     = (state_q == ST_TIMEOUT);
   end

   mon_log_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_log (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (start),
      .wr_req_i    (state_q == ST_RUN),
      .wd_i        (wd_in),
      .rd_idx_i    (rd_idx),
      .rd_data_o   (rd_data),
      .log_count_o (log_count)
   );

endmodule

// File: tb/tb_datapath_run_monitor.sv
module tb_datapath_run_monitor;

   localparam int DEPTH = 8;
   localparam int HALT  = 4;
   localparam int MAXC  = 16;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [31:0] pc_in, wd_in, expected;
   logic [2:0]  rd_idx;
   logic [31:0] rd_data;
   logic [3:0]  log_count;
   logic [15:0] cycle_count;
   logic [1:0]  state;
   logic        done, pass, timeout;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   datapath_run_monitor #(
      .DATA_W(32), .PC_W(32), .DEPTH(DEPTH), .HALT_CYCLES(HALT),
      .MAX_CYCLES(MAXC), .CNT_W(16)
   ) u_dut (
      .clk(clk), .rst(rst), .start(start), .pc_in(pc_in), .wd_in(wd_in),
      .expected(expected), .rd_idx(rd_idx), .rd_data(rd_data),
      .log_count(log_count), .cycle_count(cycle_count), .state(state),
      .done(done), .pass(pass), .timeout(timeout)
   );

   // Reference model: full PC history of the run, distinct-value log newest first.
   int          m_state;
   int          m_cyc;
   bit          m_pass;
   logic [31:0] m_pcs[$];
   logic [31:0] m_log[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_rd(input int idx);
      return (idx < m_log.size()) ? m_log[idx] : 32'h0;
   endfunction

   task automatic model_step();
      int run;
      if (rst) begin
         m_state = 0; m_cyc = 0; m_pass = 0;
         m_pcs.delete(); m_log.delete();
      end else if (start) begin
         m_state = 1; m_cyc = 0; m_pass = 0;
         m_pcs.delete(); m_log.delete();
      end else if (m_state == 1) begin
         m_cyc++;
         m_pcs.push_back(pc_in);
         if (m_log.size() == 0 || m_log[0] != wd_in) begin
            m_log.push_front(wd_in);
            if (m_log.size() > DEPTH) void'(m_log.pop_back());
         end
         run = 0;
         for (int i = m_pcs.size() - 1; i >= 0 && m_pcs[i] == pc_in; i--) run++;
         if (run >= HALT) begin
            m_state = 2;
            m_pass  = (wd_in == expected);
         end else if (m_cyc == MAXC) begin
            m_state = 3;
         end
      end
   endtask

   task automatic check_cycle();
      chk("state",     state,       m_state);
      chk("done",      done,        (m_state >= 2));
      chk("pass",      pass,        m_pass);
      chk("timeout",   timeout,     (m_state == 3));
      chk("cycles",    cycle_count, m_cyc);
      chk("log_count", log_count,   m_log.size());
      chk("rd_data",   rd_data,     m_rd(rd_idx));
   endtask

   task automatic check_log_all();
      for (int i = 0; i < DEPTH; i++) begin
         rd_idx = 3'(i);
         #1;
         chk("rd_all", rd_data, m_rd(i));
      end
   endtask

   task automatic tick(input logic r, input logic s, input logic [31:0] pc, input logic [31:0] wd);
      rst = r; start = s; pc_in = pc; wd_in = wd;
      rd_idx = 3'($urandom_range(0, 7));
      @(posedge clk);
      model_step();
      #1;
      check_cycle();
   endtask

   task automatic sad_run(input logic [31:0] exp_v);
      logic [31:0] wd;
      expected = exp_v;
      tick(0, 1, 32'h0, 32'h0);
      for (int k = 0; k < 9; k++) begin
         wd = (k < 2) ? 32'd1 : (k < 4) ? 32'd2 : (k < 8) ? 32'd3 : 32'd5;
         tick(0, 0, 32'(4 * k), wd);
      end
      for (int k = 0; k < 4; k++) tick(0, 0, 32'h24, 32'd5);
   endtask

   int          seq[14] = '{1, 1, 2, 3, 3, 4, 5, 5, 6, 7, 8, 8, 9, 10};
   logic [31:0] pc_r;

   initial begin
      rst = 1'b1; start = 1'b0; pc_in = '0; wd_in = '0; expected = '0; rd_idx = '0;
      m_state = 0; m_cyc = 0; m_pass = 0;

      // Reset with arbitrary inputs
      for (int k = 0; k < 2; k++) tick(1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      chk("rst_state", state, 0);
      chk("rst_cycles", cycle_count, 0);
      check_log_all();

      // Halt with pass
      sad_run(32'h5);
      chk("hp_done", done, 1);
      chk("hp_pass", pass, 1);
      chk("hp_logcnt", log_count, 4);
      rd_idx = 3'd0; #1; chk("hp_rd0", rd_data, 5);
      rd_idx = 3'd3; #1; chk("hp_rd3", rd_data, 1);

      // Halt with fail
      sad_run(32'h6);
      chk("hf_done", done, 1);
      chk("hf_pass", pass, 0);
      chk("hf_timeout", timeout, 0);
      chk("hf_state", state, 2);

      // Timeout: PC never repeats
      tick(0, 1, 32'h0, 32'h0);
      for (int k = 0; k < MAXC; k++) tick(0, 0, 32'(100 + 4 * k), $urandom_range(0, 3));
      chk("to_state", state, 3);
      chk("to_flag", timeout, 1);
      chk("to_pass", pass, 0);
      chk("to_cycles", cycle_count, 16);
      for (int k = 0; k < 3; k++) tick(0, 0, 32'h40, 32'h1);
      chk("to_frozen", cycle_count, 16);

      // Log wrap with duplicates
      tick(0, 1, 32'h0, 32'h0);
      for (int k = 0; k < 14; k++) tick(0, 0, 32'(200 + 4 * k), 32'(seq[k]));
      chk("wrap_cnt", log_count, 8);
      for (int i = 0; i < DEPTH; i++) begin
         rd_idx = 3'(i); #1;
         chk("wrap_rd", rd_data, 32'(10 - i));
      end

      // Restart mid-run
      tick(0, 1, 32'h0, 32'h0);
      for (int k = 0; k < 5; k++) tick(0, 0, 32'(4 * k), 32'(k + 1));
      tick(0, 1, 32'h80, 32'h9);
      chk("rs_cyc0", cycle_count, 0);
      tick(0, 0, 32'h84, 32'h9);
      chk("rs_cyc1", cycle_count, 1);
      chk("rs_logcnt", log_count, 1);

      // Halt and timeout on the same sample
      expected = 32'h7;
      tick(0, 1, 32'h0, 32'h0);
      for (int k = 0; k < 12; k++) tick(0, 0, 32'(300 + 4 * k), 32'(k));
      for (int k = 0; k < 4; k++) tick(0, 0, 32'h999, 32'h7);
      chk("col_state", state, 2);
      chk("col_pass", pass, 1);

      // Randomized runs with occasional restarts and resets
      for (int r = 0; r < 20; r++) begin
         expected = $urandom_range(0, 3);
         pc_r = 32'(4 * $urandom_range(0, 3));
         tick(0, 1, pc_r, 32'h0);
         for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 1) == 0) pc_r = 32'(4 * $urandom_range(0, 3));
            tick(($urandom_range(0, 59) == 0), ($urandom_range(0, 29) == 0),
                 pc_r, $urandom_range(0, 3));
         end
         check_log_all();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/datapath_run_monitor.md
# datapath_run_monitor

Synthesizable run monitor for the pipelined SAD datapath top level. It samples the `ProgramCounter` and `WriteData` outputs every cycle and detects program completion as a PC spin (halt loop) or a cycle-budget timeout. It keeps a circular log of the most recent distinct write-back values and reports pass/fail against an expected final result. It replaces free-running, eyeball-checked simulation with a parametrised, self-reporting harness that can also sit on an FPGA debug path.

## Interface
Parameters:
- `DATA_W`, 32: width of the write-back data.
- `PC_W`, 32: width of the program counter.
- `DEPTH`, 8: number of write-back log entries; power of two, ≥2.
- `HALT_CYCLES`, 4: number of consecutive identical PC samples that declare a halt; ≥2.
- `MAX_CYCLES`, 4096: timeout budget in RUN cycles; must be < 2^`CNT_W`.
- `CNT_W`, 16: width of the cycle counter.

Ports:
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse that arms or re-arms the monitor.
- `pc_in` input `PC_W`: the datapath's ProgramCounter.
- `wd_in` input `DATA_W`: the datapath's WriteData.
- `expected` input `DATA_W`: the expected final result; must be stable from `start` until `done`.
- `rd_idx` input log2(`DEPTH`): log read index; 0 selects the most recent entry.
- `rd_data` output `DATA_W`: the log entry selected by `rd_idx`.
- `log_count` output log2(`DEPTH`)+1: number of valid log entries.
- `cycle_count` output `CNT_W`: number of RUN cycles elapsed.
- `state` output 2: the current state, encoded IDLE=0, RUN=1, HALTED=2, TIMEOUT=3.
- `done` output 1: run finished, by halt or by timeout.
- `pass` output 1: halted with `wd_in` equal to `expected`.
- `timeout` output 1: the cycle budget was exhausted.

## Operation
- On reset, and on every `start`, the state, counters, `log_count`, write pointer, `done`, `pass` and `timeout` are cleared.
- **Reset** places the block in IDLE. **`start`** places it in RUN.
- `start` is accepted in any state, including mid-RUN, where it restarts the run. `start` takes precedence over all RUN updates in the same cycle.
- Each RUN cycle:
  - `cycle_count` increments by 1.
  - `prev_pc` is set to `pc_in`.
  - The stability counter increments if `pc_in == prev_pc`; otherwise it clears to 0. The first RUN cycle after `start` always loads `prev_pc` with a stability count of 0.
- Logging, in RUN only: when `log_count == 0` or `wd_in` differs from the newest entry, `wd_in` is written at `wr_ptr`.
  - `wr_ptr` then increments modulo `DEPTH`.
  - `log_count` saturates at `DEPTH`. When the log is full, the oldest entry is overwritten.
  - Repeated identical values are not logged.
- Halt: when a RUN sample makes the stability count equal `HALT_CYCLES`-1, the state moves to HALTED, `done`=1, and `pass`=(`wd_in`==`expected`) for that same sample.
- Timeout: when a RUN sample makes `cycle_count` equal `MAX_CYCLES` without a halt, the state moves to TIMEOUT with `done`=1, `timeout`=1, `pass`=0.
- If a halt and a timeout occur on the same sample, the halt wins.
- HALTED and TIMEOUT are sticky; only `start` or `rst` leaves them. Counters and the log freeze in these states.
- Read path is combinational: `rd_data` = `mem[(wr_ptr-1-rd_idx) mod DEPTH]` when `rd_idx < log_count`, else 0. Readout is valid in every state.

## Timing
- All outputs except `rd_data` are registered; their reset values are 0 and the state is IDLE.
- `done`, `pass` and `timeout` rise on the same edge that samples the deciding `pc_in`/`wd_in`. There is no extra latency.
- A halt is declared on the `HALT_CYCLES`-th consecutive identical PC sample, i.e. `HALT_CYCLES`-1 cycles after the PC first repeats.
- A log entry is readable on `rd_data` the cycle after it is sampled.
- `rst` asserted mid-RUN clears everything on that edge; the log contents become invalid because `log_count`=0.

## Structure
- Package `datapath_mon_pkg` holds:
  - the state enum with the encodings above;
  - the localparams for the log index width and count width.
- Sub-module `mon_log_buffer` contains:
  - the `DEPTH`×`DATA_W` register array;
  - the wrap-around write pointer, the saturating count, the duplicate filter and the combinational newest-first read mux.
- The top level contains the FSM, the cycle counter, the halt detector and the verdict logic.

## Test plan
Unless a scenario says otherwise, defaults apply: `HALT_CYCLES`=4, `MAX_CYCLES`=4096, `DEPTH`=8.

- **Reset:** `rst`=1 for 2 cycles with arbitrary inputs → `state`=0, `done`=`pass`=`timeout`=0, `cycle_count`=0, `log_count`=0, `rd_data`=0.
- **Halt with pass:** `start`; PC steps 0,4,8,…,0x20; `wd_in` 1,2,3,5; `expected`=0x5; PC holds 0x24 → `done`=1 and `pass`=1 on the 4th 0x24 sample; `log_count`=4; `rd_data`[0]=5 and [3]=1.
- **Halt with fail:** same run with `expected`=0x6 → `done`=1, `pass`=0, `timeout`=0, `state`=2.
- **Timeout:** `MAX_CYCLES`=16 with PC incrementing every cycle → on the 16th RUN sample `state`=3, `timeout`=1, `pass`=0, `cycle_count`=16; `cycle_count` frozen thereafter.
- **Log wrap and duplicates:** `wd_in` sequence 1,1,2,…,10 with duplicates interleaved → `log_count`=8; `rd_data` for indices 0..7 = 10..3.
- **Restart and priority:** `start` mid-RUN at cycle 5 → `cycle_count` reads 1 on the next cycle and `log_count` restarts. A halt and a timeout on the same sample → HALTED.
